psum_requant_ofifo: RTL
=======================

Name: psum_requant_ofifo

Overview:
- Output-side drain for the MAC array.
- Accepts 16-bit partial sums in the same number format the MAC drives out: 2's complement, or sign-magnitude when format=1.
- Decodes, rounds, right-shifts, optionally applies ReLU, saturates to 8 bits, and re-encodes in the selected format.
- Buffers results in a small FIFO with valid/ready on both sides, producing the next layer's activations.

Parameters:
- psum_bw, 16, input partial-sum width.
- bw, 8, output activation width.
- depth, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; block is held in reset while reset==0.
- format  in  1  0 = 2's complement, 1 = sign-magnitude; applies to psum_in and to out.
- relu_en  in  1  1 = clamp negative results to 0.
- shift  in  4  right-shift amount, 0..15.
- sat_clr  in  1  synchronous clear of sat_flag.
- in_valid  in  1  psum_in valid.
- in_ready  out  1  block can accept.
- psum_in  in  psum_bw  partial sum.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes head.
- out  out  bw  FIFO head; 0 when empty.
- count  out  $clog2(depth)+1  FIFO occupancy.
- sat_flag  out  1  sticky; set when any result saturated.

Behaviour:
- Reset (reset==0, asynchronous):
  - s1_valid=0, FIFO pointers=0, count=0.
  - out_valid=0, out=0, sat_flag=0.
  - in_ready=1 once reset releases.
  - Reset mid-operation discards all in-flight data immediately, without waiting for a clock edge.
- Stage S1 (input register):
  - On an edge with in_valid && in_ready, capture psum_in, format, relu_en and shift; set s1_valid=1.
  - Otherwise s1_valid=0.
  - Config is sampled per item, so changing config mid-stream affects only later items.
- Stage 2 (convert and write):
  - When s1_valid, the converted value is written into the FIFO on the next edge.
  - S1 never stalls; the in_ready rule guarantees there is room.
- in_ready = (count + s1_valid) < depth. It is a function of registers only, with no combinational path from out_ready.
- Latency: an item accepted at edge N is visible on out/out_valid after edge N+1 when the FIFO was empty.
- Throughput: 1 item/cycle when out_ready=1.
- Pop: on an edge with out_valid && out_ready, advance the read pointer.
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo depth.
- Ordering: strict FIFO order.
- Conversion arithmetic (signed, 18 bits internal, no intermediate overflow):
  1. Decode:
     - format=0: v = signed psum_in.
     - format=1: v = psum_in[15] ? -psum_in[14:0] : psum_in[14:0]. 0x8000 (negative zero) decodes to 0.
  2. Round: if shift>0, v = v + (1 << (shift-1)).
  3. Shift: v = v >>> shift (arithmetic, floor).
  4. ReLU: if relu_en and v<0, v = 0.
  5. Saturate:
     - format=0 range is [-128, 127].
     - format=1 range is [-127, 127].
     - Clamping sets sat_flag on the write edge.
  6. Encode:
     - format=0: v[7:0].
     - format=1: {sign, |v|[6:0]}. Zero is always encoded 0x00, never 0x80.
- sat_flag:
  - Sticky until sat_clr=1 on an edge.
  - sat_clr and a saturating write on the same edge leave sat_flag=1 (set wins).
- Boundary cases:
  - FIFO full (count==depth): in_ready=0, out_valid=1.
  - A pop at full raises in_ready the next cycle.
  - Empty: out=0, out_valid=0. An out_ready asserted while empty has no effect.
  - in_valid while in_ready=0 is ignored, and the item is not captured.

Test Plan:
- 2's complement path: format=0, shift=0, relu_en=0; push 0x0050, 0xFF80, 0x0100 -> out 0x50, 0x80, 0x7F in order; sat_flag=1 after the third write; first out_valid 2 edges after the first accept.
- Sign-magnitude path: format=1, shift=0; push 0x8005, 0x8000, 0x8200, 0x007F -> out 0x85, 0x00, 0xFF (saturated to -127), 0x7F.
- Rounding and ReLU: format=0, shift=4; push 0x0018 (24) -> 0x02; push 0xFFE8 (-24) -> 0xFF (-1); repeat with relu_en=1 -> 0x02, 0x00.
- Backpressure: out_ready=0 and 6 back-to-back in_valid -> exactly 4 accepted, in_ready=0 while count+s1_valid==4, count=4; then out_ready=1 -> 4 items out in order, in_ready returns 1 the cycle after the first pop.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 items -> one output per cycle, count stays at 1, no drops or duplicates.
- Async reset: reset=0 mid-cycle with count=3 and s1_valid=1 -> count=0, out_valid=0, out=0, sat_flag=0 before the next edge; after release, the first new item emerges at the standard latency.

Source files
------------

// File: rtl/psum_requant_ofifo_if.sv
// Handshake bundle for the requantiser: partial-sum input channel and activation output channel.
interface psum_requant_ofifo_if #(
    parameter int psum_bw = 16,
    parameter int bw      = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [psum_bw-1:0] psum_in;
    logic               out_valid;
    logic               out_ready;
    logic [bw-1:0]      out;

    modport master (
        output in_valid, psum_in, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, psum_in, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/psum_requant_ofifo.sv
// MAC output drain: decode, round, shift, ReLU, saturate and re-encode partial sums,
// then buffer the resulting activations in a small valid/ready FIFO.
module psum_requant_ofifo #(
    parameter int psum_bw = 16,
    parameter int bw      = 8,
    parameter int depth   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     format,
    input  logic                     relu_en,
    input  logic [3:0]               shift,
    input  logic                     sat_clr,
    psum_requant_ofifo_if.slave      bus,
    output logic [$clog2(depth):0]   count,
    output logic                     sat_flag
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam int w  = psum_bw + 2;
    localparam logic signed [w-1:0] pos_lim = w'(2 ** (bw - 1) - 1);
    localparam logic signed [w-1:0] neg_lim_tc = -pos_lim - w'(1);
    localparam logic signed [w-1:0] neg_lim_sm = -pos_lim;
    localparam logic [cw:0] depth_c = (cw + 1)'(depth);

    logic               s1_valid;
    logic [psum_bw-1:0] s1_psum;
    logic               s1_fmt;
    logic               s1_relu;
    logic [3:0]         s1_shift;

    logic [bw-1:0] mem [depth];
    logic [aw-1:0] wptr;
    logic [aw-1:0] rptr;

    logic               push;
    logic               pop;
    logic               accept;
    logic signed [w-1:0] mag;
    logic signed [w-1:0] dec;
    logic        [w-1:0] rnd_add;
    logic signed [w-1:0] rnd;
    logic signed [w-1:0] shf;
    logic signed [w-1:0] rel;
    logic signed [w-1:0] neg_lim;
    logic signed [w-1:0] sat_v;
    logic signed [w-1:0] abs_v;
    logic                sat;
    logic [bw-1:0]       result;

    // in_ready counts the item sitting in S1 so S2 never finds the FIFO full.
    assign bus.in_ready  = ({1'b0, count} + (cw + 1)'(s1_valid)) < depth_c;
    assign bus.out_valid = (count != '0);
    assign bus.out       = (count != '0) ? mem[rptr] : '0;
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = s1_valid;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_psum  <= '0;
            s1_fmt   <= 1'b0;
            s1_relu  <= 1'b0;
            s1_shift <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_psum  <= bus.psum_in;
                s1_fmt   <= format;
                s1_relu  <= relu_en;
                s1_shift <= shift;
            end
        end
    end

    always_comb begin
        mag     = {3'b000, s1_psum[psum_bw-2:0]};
        dec     = s1_fmt ? (s1_psum[psum_bw-1] ? -mag : mag)
                         : {{2{s1_psum[psum_bw-1]}}, s1_psum};
        rnd_add = '0;
        if (s1_shift != 4'd0) rnd_add = w'(1) << (s1_shift - 4'd1);
        rnd     = dec + $signed(rnd_add);
        shf     = rnd >>> s1_shift;
        rel     = (s1_relu && shf[w-1]) ? '0 : shf;
        neg_lim = s1_fmt ? neg_lim_sm : neg_lim_tc;
        sat     = 1'b0;
        sat_v   = rel;
        if (rel > pos_lim) begin
            sat_v = pos_lim;
            sat   = 1'b1;
        end else if (rel < neg_lim) begin
            sat_v = neg_lim;
            sat   = 1'b1;
        end
        abs_v  = -sat_v;
        result = sat_v[bw-1:0];
        if (s1_fmt && sat_v[w-1]) result = {1'b1, abs_v[bw-2:0]};
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= result;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (push) wptr <= wptr + aw'(1);
            if (pop)  rptr <= rptr + aw'(1);
            case ({push, pop})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
            // A saturating write wins over a simultaneous clear.
            if (push && sat)  sat_flag <= 1'b1;
            else if (sat_clr) sat_flag <= 1'b0;
        end
    end
endmodule
